cp0_regfile: RTL and testbench

Coprocessor-0 register file for the MIPS pipeline: the consumer of the exception unit's resolved except_type. It holds BadVAddr, Count, Compare, Status, Cause, EPC and PRId. On an exception commit it updates Status.EXL, Cause.BD/ExcCode, EPC and BadVAddr, and it clears EXL on ERET. It also services MTC0/MFC0, runs the Count/Compare timer and feeds status_o, cause_o and epc_o back to the exception unit. It sits beside the M/W boundary.

---
 rtl/cp0_regfile_pkg.sv | 59 +++++
 rtl/cp0_regfile_timer.sv | 52 +++++
 rtl/cp0_regfile.sv | 144 ++++++++++++++
 tb/tb_cp0_regfile.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 constants: register numbers, except_type codes, ExcCode values
// and Status/Cause field positions, common to CP0 and the exception unit.
package cp0_regfile_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  localparam logic [31:0] EXC_NONE = 32'h0;
  localparam logic [31:0] EXC_INT  = 32'h1;
  localparam logic [31:0] EXC_ADEL = 32'h4;
  localparam logic [31:0] EXC_ADES = 32'h5;
  localparam logic [31:0] EXC_SYS  = 32'h8;
  localparam logic [31:0] EXC_BP   = 32'h9;
  localparam logic [31:0] EXC_RI   = 32'ha;
  localparam logic [31:0] EXC_OV   = 32'hc;
  localparam logic [31:0] EXC_ERET = 32'he;

  localparam logic [4:0] CODE_INT  = 5'h00;
  localparam logic [4:0] CODE_ADEL = 5'h04;
  localparam logic [4:0] CODE_ADES = 5'h05;
  localparam logic [4:0] CODE_SYS  = 5'h08;
  localparam logic [4:0] CODE_BP   = 5'h09;
  localparam logic [4:0] CODE_RI   = 5'h0a;
  localparam logic [4:0] CODE_OV   = 5'h0c;

  localparam int ST_IE   = 0;
  localparam int ST_EXL  = 1;
  localparam int ST_IM_LO = 8;
  localparam int ST_BEV  = 22;
  localparam int CA_EXC_LO = 2;
  localparam int CA_IP_LO  = 8;
  localparam int CA_IPH_LO = 10;
  localparam int CA_TI   = 30;
  localparam int CA_BD   = 31;

  // Only these types commit an exception; any other nonzero code is a no-op.
  function automatic logic is_exc(input logic [31:0] t);
    return t == EXC_INT || t == EXC_ADEL || t == EXC_ADES || t == EXC_SYS ||
           t == EXC_BP  || t == EXC_RI   || t == EXC_OV;
  endfunction

  function automatic logic [4:0] exc_code(input logic [31:0] t);
    case (t)
      EXC_ADEL: return CODE_ADEL;
      EXC_ADES: return CODE_ADES;
      EXC_SYS:  return CODE_SYS;
      EXC_BP:   return CODE_BP;
      EXC_RI:   return CODE_RI;
      EXC_OV:   return CODE_OV;
      default:  return CODE_INT;
    endcase
  endfunction

endpackage

// File: rtl/cp0_regfile_timer.sv
// Count/Compare timer: half-rate Count, Compare match and sticky timer interrupt.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  logic        tick_q, tick_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        timer_int_q, timer_int_d;

  always_comb begin
    tick_d      = ~tick_q;
    count_d     = count_q;
    compare_d   = compare_q;
    timer_int_d = timer_int_q;
    if (count_we_i)  count_d = wdata_i;
    else if (tick_q) count_d = count_q + 32'd1;
    // Writing Compare acknowledges the interrupt and masks a same-cycle match.
    if (compare_we_i) begin
      compare_d   = wdata_i;
      timer_int_d = 1'b0;
    end else if (count_q == compare_q && compare_q != 32'd0) begin
      timer_int_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q      <= 1'b0;
      count_q     <= '0;
      compare_q   <= '0;
      timer_int_q <= 1'b0;
    end else begin
      tick_q      <= tick_d;
      count_q     <= count_d;
      compare_q   <= compare_d;
      timer_int_q <= timer_int_d;
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = timer_int_q;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: MTC0/MFC0 access, exception/ERET commit and timer.
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h00004220
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] data_o,
  input  logic [5:0]  int_i,
  input  logic [31:0] except_type_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] badvaddr_o,
  output logic        timer_int_o
);

  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d, ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [31:0] epc_q, epc_d, badvaddr_q, badvaddr_d;
  logic        exc_vld, eret, adr_err;

  cp0_timer u_timer (
    .clk         (clk),
    .rst         (rst),
    .count_we_i  (we_i && waddr_i == REG_COUNT),
    .compare_we_i(we_i && waddr_i == REG_COMPARE),
    .wdata_i     (data_i),
    .count_o     (count_o),
    .compare_o   (compare_o),
    .timer_int_o (timer_int_o)
  );

  always_comb begin
    exc_vld    = is_exc(except_type_i);
    eret       = except_type_i == EXC_ERET;
    adr_err    = except_type_i == EXC_ADEL || except_type_i == EXC_ADES;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    exccode_d  = exccode_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    ip_hw_d    = {int_i[5] | timer_int_o, int_i[4:0]};

    // A hardware update owns the whole register for the cycle; MTC0 to it drops.
    if (we_i) begin
      case (waddr_i)
        REG_STATUS: if (!exc_vld && !eret) begin
          im_d  = data_i[ST_IM_LO +: 8];
          exl_d = data_i[ST_EXL];
          ie_d  = data_i[ST_IE];
        end
        REG_CAUSE:    if (!exc_vld) ip_sw_d = data_i[CA_IP_LO +: 2];
        REG_EPC:      if (!exc_vld) epc_d = data_i;
        REG_BADVADDR: if (!(exc_vld && adr_err)) badvaddr_d = data_i;
        default: ;
      endcase
    end

    if (exc_vld) begin
      exl_d     = 1'b1;
      exccode_d = exc_code(except_type_i);
      if (!exl_q) begin
        epc_d = is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
        bd_d  = is_in_delayslot_i;
      end
      if (adr_err) badvaddr_d = bad_addr_i;
    end else if (eret) begin
      exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_hw_q    <= '0;
      ip_sw_q    <= '0;
      exccode_q  <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      exccode_q  <= exccode_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  always_comb begin
    status_o                   = '0;
    status_o[ST_BEV]           = 1'b1;
    status_o[ST_IM_LO +: 8]    = im_q;
    status_o[ST_EXL]           = exl_q;
    status_o[ST_IE]            = ie_q;
    cause_o                    = '0;
    cause_o[CA_BD]             = bd_q;
    cause_o[CA_TI]             = timer_int_o;
    cause_o[CA_IPH_LO +: 6]    = ip_hw_q;
    cause_o[CA_IP_LO +: 2]     = ip_sw_q;
    cause_o[CA_EXC_LO +: 5]    = exccode_q;
  end

  assign epc_o      = epc_q;
  assign badvaddr_o = badvaddr_q;

  always_comb begin
    case (raddr_i)
      REG_BADVADDR: data_o = badvaddr_q;
      REG_COUNT:    data_o = count_o;
      REG_COMPARE:  data_o = compare_o;
      REG_STATUS:   data_o = status_o;
      REG_CAUSE:    data_o = cause_o;
      REG_EPC:      data_o = epc_q;
      REG_PRID:     data_o = PRID;
      default:      data_o = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile: exceptions, ERET, MTC0 priority, timer, wrap.
module tb_cp0_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we_i = 1'b0;
  logic [4:0]  waddr_i = '0, raddr_i = '0;
  logic [31:0] data_i = '0, data_o;
  logic [5:0]  int_i = '0;
  logic [31:0] except_type_i = '0, current_inst_addr_i = '0, bad_addr_i = '0;
  logic        is_in_delayslot_i = 1'b0;
  logic [31:0] status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o;
  logic        timer_int_o;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  cp0_regfile dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .data_i(data_i),
    .raddr_i(raddr_i), .data_o(data_o), .int_i(int_i),
    .except_type_i(except_type_i), .current_inst_addr_i(current_inst_addr_i),
    .is_in_delayslot_i(is_in_delayslot_i), .bad_addr_i(bad_addr_i),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .count_o(count_o),
    .compare_o(compare_o), .badvaddr_o(badvaddr_o), .timer_int_o(timer_int_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; data_i = d;
    step();
    we_i = 1'b0;
  endtask

  task automatic raise(input logic [31:0] t, input logic [31:0] pc, input logic ds,
                       input logic [31:0] ba);
    except_type_i = t; current_inst_addr_i = pc; is_in_delayslot_i = ds; bad_addr_i = ba;
    step();
    except_type_i = '0; is_in_delayslot_i = 1'b0;
  endtask

  task automatic mfc0(input string tag, input logic [4:0] a, input logic [31:0] exp);
    raddr_i = a;
    #1;
    chk(tag, data_o, exp);
  endtask

  initial begin
    do_reset();
    chk("rst_status", status_o, 32'h00400000);
    chk("rst_cause", cause_o, 32'h0);
    chk("rst_epc", epc_o, 32'h0);
    chk("rst_count", count_o, 32'h0);
    chk("rst_compare", compare_o, 32'h0);
    chk("rst_badvaddr", badvaddr_o, 32'h0);
    chk("rst_timer", {31'b0, timer_int_o}, 32'h0);
    mfc0("mfc0_prid", 5'd15, 32'h00004220);
    mfc0("mfc0_status", 5'd12, 32'h00400000);

    // Syscall then ERET
    raise(32'h8, 32'hBFC00100, 1'b0, 32'h0);
    chk("sys_epc", epc_o, 32'hBFC00100);
    chk("sys_cause", cause_o, 32'h00000020);
    chk("sys_status", status_o, 32'h00400002);
    raise(32'he, 32'h0, 1'b0, 32'h0);
    chk("eret_status", status_o, 32'h00400000);
    chk("eret_epc", epc_o, 32'hBFC00100);
    chk("eret_cause", cause_o, 32'h00000020);

    // AdEL in a delay slot, then nested exception with EXL=1
    raise(32'h4, 32'h80000024, 1'b1, 32'h80000026);
    chk("adel_epc", epc_o, 32'h80000020);
    chk("adel_cause", cause_o, 32'h80000010);
    chk("adel_badvaddr", badvaddr_o, 32'h80000026);
    chk("adel_status", status_o, 32'h00400002);
    mfc0("mfc0_badvaddr", 5'd8, 32'h80000026);
    raise(32'h8, 32'h00000100, 1'b0, 32'h0);
    chk("nest_epc", epc_o, 32'h80000020);
    chk("nest_cause", cause_o, 32'h80000020);
    raise(32'h3, 32'h00000200, 1'b0, 32'h0);
    chk("noop_type_cause", cause_o, 32'h80000020);

    // Simultaneous MTC0 and exception
    do_reset();
    we_i = 1'b1; waddr_i = 5'd14; data_i = 32'h1234;
    raise(32'hc, 32'h00000080, 1'b0, 32'h0);
    we_i = 1'b0;
    chk("ov_epc", epc_o, 32'h00000080);
    chk("ov_cause", cause_o, 32'h00000030);
    we_i = 1'b1; waddr_i = 5'd11; data_i = 32'h55;
    raise(32'h8, 32'h00000090, 1'b0, 32'h0);
    we_i = 1'b0;
    chk("exc_mtc0_compare", compare_o, 32'h55);
    chk("exc_mtc0_epc_held", epc_o, 32'h00000080);
    mtc0(5'd12, 32'hFFFFFFFF);
    chk("status_mask", status_o, 32'h0040FF03);
    mtc0(5'd3, 32'hDEADBEEF);
    mfc0("mfc0_unused", 5'd3, 32'h0);

    // External interrupt sampling
    do_reset();
    mtc0(5'd12, 32'h00000401);
    chk("im_status", status_o, 32'h00400401);
    int_i = 6'b000001;
    #1;
    chk("ip_not_yet", cause_o, 32'h0);
    step();
    chk("ip_sampled", cause_o, 32'h00000400);
    int_i = '0;
    mtc0(5'd13, 32'hFFFFFFFF);
    chk("cause_sw_ip", cause_o, 32'h00000300);

    // Timer: Compare written at edge 1, Count reaches 10 at edge 20
    do_reset();
    mtc0(5'd11, 32'd10);
    for (int i = 2; i <= 20; i++) step();
    chk("tmr_count20", count_o, 32'd10);
    chk("tmr_low20", {31'b0, timer_int_o}, 32'h0);
    step();
    chk("tmr_high21", {31'b0, timer_int_o}, 32'h1);
    chk("tmr_count21", count_o, 32'd10);
    step();
    chk("tmr_cause22", cause_o, 32'h40008000);
    mtc0(5'd11, 32'd20);
    chk("tmr_clear", {31'b0, timer_int_o}, 32'h0);
    chk("tmr_compare", compare_o, 32'd20);

    // Count wrap
    do_reset();
    mtc0(5'd9, 32'hFFFFFFFF);
    chk("wrap_load", count_o, 32'hFFFFFFFF);
    step();
    chk("wrap_zero", count_o, 32'h0);

    // Reset beats exception, MTC0 and increment
    mtc0(5'd12, 32'h00000401);
    we_i = 1'b1; waddr_i = 5'd9; data_i = 32'h77;
    except_type_i = 32'h8; current_inst_addr_i = 32'h40;
    do_reset();
    we_i = 1'b0; except_type_i = '0;
    chk("rst_ovr_status", status_o, 32'h00400000);
    chk("rst_ovr_count", count_o, 32'h0);
    chk("rst_ovr_epc", epc_o, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
